// File: rtl/pipelined_reducer.sv
// Purpose : pipelined PORT_NUM-word reducer (AND / OR / XOR across ports, or full AND to one bit), one tree level per clock.
// Latency : L = max(1, clog2(PORT_NUM)) cycles from acceptance to a visible result; 1 beat/cycle sustained.
// Backpr. : global advance (adv = !out_valid || out_ready) moves or holds every stage at once; in_ready = adv.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   in_data               PORT_NUM flattened words, port i at [i*WIDTH +: WIDTH]
//   in_mode               0 AND, 1 OR, 2 XOR, 3 full-AND (travels with the beat)
//   out_valid / out_ready result handshake
//   out_q                 WIDTH-bit result
module pipelined_reducer #(
  parameter int PORT_NUM = 8,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PORT_NUM*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_q
);

  localparam int L      = (PORT_NUM <= 2) ? 1 : $clog2(PORT_NUM);
  localparam int LEAVES = 1 << L;
  // All tree levels are stored in one flat node array: stage s starts at
  // word LEAVES - (LEAVES >> s) and holds LEAVES >> (s+1) words.
  localparam int NODES  = LEAVES - 1;

  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_FULL = 2'd3;

  typedef logic [WIDTH-1:0] word_t;

  // Full-AND reduces the tree with plain AND; the collapse to one bit
  // happens only at the output.
  function automatic word_t red_op(input logic [1:0] mode, input word_t a, input word_t b);
    word_t r;
    case (mode)
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

  logic [L-1:0]            vld_q, vld_d;
  logic [L-1:0][1:0]       mode_q, mode_d;
  logic [NODES-1:0][WIDTH-1:0] dat_q, dat_d;

  logic [LEAVES-1:0][WIDTH-1:0] leaf;
  logic  adv;
  word_t tree;
  word_t full_and;

  // Single advance for every stage: bubbles are carried, never collapsed,
  // so ordering and timing stay trivially predictable.
  always_comb begin
    adv = !vld_q[L-1] || out_ready;
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[L-1];

  // Leaves beyond PORT_NUM get the identity of the beat's operator so they
  // cannot disturb the result: ones for AND/full-AND, zeros for OR/XOR.
  always_comb begin
    leaf = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      leaf[i] = in_data[i*WIDTH +: WIDTH];
    end
    for (int i = PORT_NUM; i < LEAVES; i++) begin
      leaf[i] = (in_mode == MODE_OR || in_mode == MODE_XOR) ? '0 : '1;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    dat_d  = dat_q;
    if (adv) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      for (int i = 0; i < LEAVES / 2; i++) begin
        dat_d[i] = red_op(in_mode, leaf[2*i], leaf[2*i+1]);
      end
      for (int s = 1; s < L; s++) begin
        vld_d[s]  = vld_q[s-1];
        mode_d[s] = mode_q[s-1];
        for (int i = 0; i < (LEAVES >> (s + 1)); i++) begin
          dat_d[(LEAVES - (LEAVES >> s)) + i] =
            red_op(mode_q[s-1],
                   dat_q[(LEAVES - (LEAVES >> (s - 1))) + 2*i],
                   dat_q[(LEAVES - (LEAVES >> (s - 1))) + 2*i + 1]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      dat_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      dat_q  <= dat_d;
    end
  end

  // Output is a pure function of last-stage flops (no input-to-output path
  // besides in_ready); reset data/mode of zero gives out_q = 0.
  always_comb begin
    tree        = dat_q[NODES-1];
    full_and    = '0;
    full_and[0] = &tree;
    out_q       = (mode_q[L-1] == MODE_FULL) ? full_and : tree;
  end

endmodule
